dp_arbiter: RTL and testbench
=============================

DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 clk  in  1  system clock; every flop is on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ce_1, ce_2  in  1 each  phase clock enables; state advances only when ce_1|ce_2.
REQ-004 rq_addr[3]  in  16  per-requester offset (io port when rq_io).
REQ-005 rq_dout[3]  in  16  per-requester write data.
REQ-006 rq_sreg[3]  in  sreg_index_e  per-requester segment select.
REQ-007 rq_write[3], rq_wide[3], rq_io[3]  in  1 each  per-requester transfer attributes.
REQ-008 rq_req[3]  in  1 each  per-requester toggle request; pending while rq_req[i] != ack[i].
REQ-009 rq_ready[3]  out  1 each  combinational, rq_req[i] == ack[i].
REQ-010 rq_din  out  16  shared read-data register.
REQ-011 dp_addr, dp_dout  out  16 each  forwarded to the bus control unit.
REQ-012 dp_sreg  out  sreg_index_e  forwarded segment select.
REQ-013 dp_write, dp_wide, dp_io  out  1 each  forwarded attributes.
REQ-014 dp_req  out  1  toggle request to the bus control unit.
REQ-015 dp_ready  in  1  bus control unit done (dp_req == its ack).
REQ-016 dp_din  in  16  read data from the bus control unit.
REQ-017 grant_id  out  2  index of the granted requester; 3 when none is granted.
REQ-018 implementation_fault  out  1  sticky protocol-violation flag.

Function
REQ-019 The FSM SHALL have three states: ARB_IDLE, ARB_WAIT and ARB_RELEASE.
REQ-020 In ARB_IDLE, on a cycle with ce_1 and at least one requester pending, the block SHALL, at that same edge:
 - choose winner g;
 - latch the rq_* fields of g into dp_addr/dp_dout/dp_sreg/dp_write/dp_wide/dp_io;
 - latch rq_req[g] into granted_tag;
 - invert dp_req;
 - set grant_id=g;
 - go to ARB_WAIT.
REQ-021 ARB_IDLE SHALL make no grant on a ce_2-only cycle.
REQ-022 In ARB_WAIT, on a ce_1|ce_2 cycle with dp_ready=1, the block SHALL:
 - set ack[g] to granted_tag;
 - load rq_din from dp_din if dp_write=0 (rq_din unchanged on writes);
 - go to ARB_RELEASE.
REQ-023 ARB_RELEASE SHALL last one ce_1|ce_2 cycle, set grant_id=3, then return to ARB_IDLE (one enable of turnaround before the next grant).
REQ-024 The dp_* outputs SHALL hold their latched values, unchanged, from grant until the next grant.
REQ-025 If rq_req[g] changes while g is in ARB_WAIT, the in-flight transfer SHALL complete normally and implementation_fault SHALL be set to 1.
REQ-026 A requester that toggles twice before being granted SHALL be treated as not pending (withdrawn); no fault is raised.
REQ-027 Simultaneous pending requests SHALL be resolved per REQ-033/REQ-034; losers stay pending and are unaffected.
REQ-028 A requester SHALL NOT be granted twice within one grant sequence; re-pending is evaluated only in ARB_IDLE.
REQ-029 Latency:
 - minimum 1 clk from pending at ce_1 to dp_req toggle;
 - minimum 1 clk from dp_ready=1 (ce) to rq_ready[g]=1.

Reset
REQ-030 On reset, the block SHALL set:
 - state=ARB_IDLE;
 - ack[0..2]=0;
 - dp_req=0;
 - granted_tag=0;
 - grant_id=3;
 - rq_din=16'hffff;
 - dp_addr=0, dp_dout=0, dp_sreg=DS0, dp_write=0, dp_wide=0, dp_io=0;
 - implementation_fault=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer; no ack SHALL update and no rq_din SHALL load on that edge.
REQ-032 Reset SHALL take effect regardless of ce_1/ce_2.

Configuration
REQ-033 With DP_ARB_ROUND_ROBIN_EN defined, priority SHALL rotate: the last-granted requester becomes lowest and the search starts at (last+1) mod 3; after reset, last=2.
REQ-034 Without DP_ARB_ROUND_ROBIN_EN, priority SHALL be fixed: 0 > 1 > 2.

Verification
REQ-035 Single read: rq_req[1] toggles, rq_addr[1]=16'h1234, rq_wide=1, dp_din=16'hbeef when dp_ready returns -> dp_addr=16'h1234, dp_req toggles at first ce_1, rq_din=16'hbeef, rq_ready[1]=1, grant_id=3 after ARB_RELEASE.
REQ-036 Contention with 0 and 2 pending together -> requester 0 is served first, then requester 2; dp_req toggles twice, separated by at least one ARB_RELEASE cycle.
REQ-037 Round robin (macro on): requesters 0, 1 and 2 repeatedly re-pending -> grant order 0, 1, 2, 0, 1, 2; with macro off, requester 0 is served every time.
REQ-038 Write: rq_write[2]=1, rq_dout[2]=16'h5a5a, rq_din preloaded 16'h1111 -> dp_dout=16'h5a5a, rq_din stays 16'h1111, ack[2] updates.
REQ-039 Protocol violation: requester 0 toggles rq_req[0] during ARB_WAIT -> transfer completes, implementation_fault=1, requester 0 pending again afterwards.
REQ-040 Reset during ARB_WAIT -> all outputs return to REQ-030 values, rq_ready[0..2]=1 with rq_req=0, and dp_req=0.

Source files
------------

// File: rtl/dp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dp_arbiter
// Purpose  : Three-requester toggle-handshake arbiter in front of the bus
//            control unit. Optional rotating priority via DP_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dp_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1,
    input  logic        ce_2,
    input  logic [15:0] rq_addr [0:2],
    input  logic [15:0] rq_dout [0:2],
    input  logic [1:0]  rq_sreg [0:2],
    input  logic [2:0]  rq_write,
    input  logic [2:0]  rq_wide,
    input  logic [2:0]  rq_io,
    input  logic [2:0]  rq_req,
    output logic [2:0]  rq_ready,
    output logic [15:0] rq_din,
    output logic [15:0] dp_addr,
    output logic [15:0] dp_dout,
    output logic [1:0]  dp_sreg,
    output logic        dp_write,
    output logic        dp_wide,
    output logic        dp_io,
    output logic        dp_req,
    input  logic        dp_ready,
    input  logic [15:0] dp_din,
    output logic [1:0]  grant_id,
    output logic        implementation_fault
);

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam logic [1:0]  GRANT_NONE = 2'd3;
    localparam logic [1:0]  SREG_DS0   = 2'd0;
    localparam logic [15:0] DIN_RESET  = 16'hffff;

    arb_state_e  state_q;
    logic [2:0]  ack_q;
    logic        granted_tag_q;
    logic [1:0]  grant_id_q;
    logic [15:0] rq_din_q;
    logic [15:0] dp_addr_q;
    logic [15:0] dp_dout_q;
    logic [1:0]  dp_sreg_q;
    logic        dp_write_q;
    logic        dp_wide_q;
    logic        dp_io_q;
    logic        dp_req_q;
    logic        fault_q;

    logic [2:0]  pending_d;
    logic        win_valid_d;
    logic [1:0]  win_id_d;
    logic        ce_any;

    assign pending_d = rq_req ^ ack_q;
    assign rq_ready  = ~pending_d;
    assign ce_any    = ce_1 | ce_2;

`ifdef DP_ARB_ROUND_ROBIN_EN
    logic [1:0] last_q;

    // Requester searched at position k after the last winner, modulo 3.
    function automatic logic [1:0] rr_index(input logic [1:0] last, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, last} + {1'b0, k} + 3'd1;
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    always_comb begin
        win_valid_d = 1'b0;
        win_id_d    = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (pending_d[rr_index(last_q, 2'(k))]) begin
                win_valid_d = 1'b1;
                win_id_d    = rr_index(last_q, 2'(k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 2'd2;
        end else if (state_q == ARB_IDLE && ce_1 && win_valid_d) begin
            last_q <= win_id_d;
        end
    end
`else
    always_comb begin
        win_valid_d = |pending_d;
        win_id_d    = 2'd0;
        if (pending_d[0]) begin
            win_id_d = 2'd0;
        end else if (pending_d[1]) begin
            win_id_d = 2'd1;
        end else if (pending_d[2]) begin
            win_id_d = 2'd2;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            ack_q         <= 3'b000;
            granted_tag_q <= 1'b0;
            grant_id_q    <= GRANT_NONE;
            rq_din_q      <= DIN_RESET;
            dp_addr_q     <= 16'h0000;
            dp_dout_q     <= 16'h0000;
            dp_sreg_q     <= SREG_DS0;
            dp_write_q    <= 1'b0;
            dp_wide_q     <= 1'b0;
            dp_io_q       <= 1'b0;
            dp_req_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            // A granted requester must hold its toggle until acknowledged.
            if (state_q == ARB_WAIT && rq_req[grant_id_q] != granted_tag_q) begin
                fault_q <= 1'b1;
            end
            if (ce_any) begin
                case (state_q)
                    ARB_IDLE: begin
                        if (ce_1 && win_valid_d) begin
                            dp_addr_q     <= rq_addr[win_id_d];
                            dp_dout_q     <= rq_dout[win_id_d];
                            dp_sreg_q     <= rq_sreg[win_id_d];
                            dp_write_q    <= rq_write[win_id_d];
                            dp_wide_q     <= rq_wide[win_id_d];
                            dp_io_q       <= rq_io[win_id_d];
                            granted_tag_q <= rq_req[win_id_d];
                            dp_req_q      <= ~dp_req_q;
                            grant_id_q    <= win_id_d;
                            state_q       <= ARB_WAIT;
                        end
                    end
                    ARB_WAIT: begin
                        if (dp_ready) begin
                            ack_q[grant_id_q] <= granted_tag_q;
                            if (!dp_write_q) begin
                                rq_din_q <= dp_din;
                            end
                            state_q <= ARB_RELEASE;
                        end
                    end
                    ARB_RELEASE: begin
                        grant_id_q <= GRANT_NONE;
                        state_q    <= ARB_IDLE;
                    end
                    default: begin
                        state_q <= ARB_IDLE;
                    end
                endcase
            end
        end
    end

    assign rq_din               = rq_din_q;
    assign dp_addr              = dp_addr_q;
    assign dp_dout              = dp_dout_q;
    assign dp_sreg              = dp_sreg_q;
    assign dp_write             = dp_write_q;
    assign dp_wide              = dp_wide_q;
    assign dp_io                = dp_io_q;
    assign dp_req               = dp_req_q;
    assign grant_id             = grant_id_q;
    assign implementation_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_arbiter.sv
`default_nettype none
// Self-checking bench for dp_arbiter with a transaction-level priority model.
module tb_dp_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ce_1, ce_2;
    logic [15:0] rq_addr [0:2];
    logic [15:0] rq_dout [0:2];
    logic [1:0]  rq_sreg [0:2];
    logic [2:0]  rq_write, rq_wide, rq_io, rq_req, rq_ready;
    logic [15:0] rq_din, dp_addr, dp_dout, dp_din;
    logic [1:0]  dp_sreg, grant_id;
    logic        dp_write, dp_wide, dp_io, dp_req, dp_ready, implementation_fault;
    logic        bcu_ack;

    assign dp_ready = (dp_req == bcu_ack);

    int          total = 0;
    int          bad   = 0;
    logic [2:0]  ack_m;
    int          last_m;
    logic [15:0] din_m;

    dp_arbiter dut (
        .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2),
        .rq_addr(rq_addr), .rq_dout(rq_dout), .rq_sreg(rq_sreg),
        .rq_write(rq_write), .rq_wide(rq_wide), .rq_io(rq_io),
        .rq_req(rq_req), .rq_ready(rq_ready), .rq_din(rq_din),
        .dp_addr(dp_addr), .dp_dout(dp_dout), .dp_sreg(dp_sreg),
        .dp_write(dp_write), .dp_wide(dp_wide), .dp_io(dp_io),
        .dp_req(dp_req), .dp_ready(dp_ready), .dp_din(dp_din),
        .grant_id(grant_id), .implementation_fault(implementation_fault)
    );

    function automatic bit pend_m(input int i);
        return rq_req[i] != ack_m[i];
    endfunction

    // Model priority: fixed 0>1>2, or rotating search starting after the last winner.
    function automatic int pick_m();
        int start;
`ifdef DP_ARB_ROUND_ROBIN_EN
        start = (last_m + 1) % 3;
`else
        start = 0;
`endif
        for (int k = 0; k < 3; k++) begin
            if (pend_m((start + k) % 3)) return (start + k) % 3;
        end
        return 3;
    endfunction

    task automatic tick(input logic c1, input logic c2);
        ce_1 = c1;
        ce_2 = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_rnd();
        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic respond(input logic [15:0] din);
        dp_din  = din;
        bcu_ack = dp_req;
    endtask

    task automatic wait_grant(input string tag, input bit rnd);
        logic start;
        int   n;
        start = dp_req;
        n = 0;
        while (dp_req === start && n < 60) begin
            if (rnd) tick_rnd(); else tick(1'b1, 1'b1);
            n++;
        end
        if (dp_req === start) begin
            total++; bad++;
            $display("FAIL %s_grant_timeout: dp_req=%0b, required a toggle", tag, dp_req);
        end
    endtask

    task automatic wait_idle(input string tag, input bit rnd);
        int n;
        n = 0;
        while (grant_id !== 2'd3 && n < 60) begin
            if (rnd) tick_rnd(); else tick(1'b1, 1'b1);
            n++;
        end
        if (grant_id !== 2'd3) begin
            total++; bad++;
            $display("FAIL %s_idle_timeout: grant_id=%0d, required 3", tag, grant_id);
        end
    endtask

    task automatic new_req(input int i);
        rq_req[i]   = ~rq_req[i];
        rq_addr[i]  = 16'($urandom);
        rq_dout[i]  = 16'($urandom);
        rq_sreg[i]  = 2'($urandom_range(0, 3));
        rq_write[i] = 1'($urandom_range(0, 1));
        rq_wide[i]  = 1'($urandom_range(0, 1));
        rq_io[i]    = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rq_addr[i] = 16'h0;
            rq_dout[i] = 16'h0;
            rq_sreg[i] = 2'd0;
        end
        rq_write = '0; rq_wide = '0; rq_io = '0; rq_req = '0;
        bcu_ack = 1'b0; dp_din = 16'h0;
        ack_m = '0; last_m = 2; din_m = 16'hffff;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rq_din !== 16'hffff) begin bad++; $display("FAIL reset_rq_din: got %h want ffff", rq_din); end
        total++; if ({dp_addr, dp_dout} !== 32'h0) begin bad++; $display("FAIL reset_dp_data: got %h/%h want 0/0", dp_addr, dp_dout); end
        total++; if ({dp_sreg, dp_write, dp_wide, dp_io, dp_req} !== 6'b0) begin bad++; $display("FAIL reset_dp_attr: got %b want 000000", {dp_sreg, dp_write, dp_wide, dp_io, dp_req}); end
        total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
        total++; if (implementation_fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", implementation_fault); end
        total++; if (rq_ready !== 3'b111) begin bad++; $display("FAIL reset_rq_ready: got %b want 111", rq_ready); end
    endtask

    task automatic test_single_read();
        do_reset();
        rq_req[1] = 1'b1; rq_addr[1] = 16'h1234; rq_wide[1] = 1'b1;
        tick(1'b0, 1'b1);
        total++; if ({dp_req, grant_id} !== 3'b011) begin bad++; $display("FAIL read_ce2_no_grant: got req=%b id=%0d want req=0 id=3", dp_req, grant_id); end
        tick(1'b1, 1'b0);
        total++; if ({dp_req, grant_id} !== 3'b101) begin bad++; $display("FAIL read_grant: got req=%b id=%0d want req=1 id=1", dp_req, grant_id); end
        total++; if ({dp_addr, dp_wide, dp_write} !== {16'h1234, 2'b10}) begin bad++; $display("FAIL read_dp_fields: got %h wide=%b wr=%b want 1234 1 0", dp_addr, dp_wide, dp_write); end
        tick(1'b1, 1'b1);
        total++; if (rq_ready[1] !== 1'b0) begin bad++; $display("FAIL read_wait_busy: got ready=%b want 0", rq_ready[1]); end
        respond(16'hbeef);
        tick(1'b0, 1'b1);
        total++; if ({rq_ready[1], rq_din} !== {1'b1, 16'hbeef}) begin bad++; $display("FAIL read_complete: got ready=%b din=%h want 1 beef", rq_ready[1], rq_din); end
        tick(1'b1, 1'b0);
        total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL read_release: got id=%0d want 3", grant_id); end
    endtask

    task automatic test_contention();
        int idle_seen;
        do_reset();
        rq_req[0] = 1'b1; rq_addr[0] = 16'h0a00;
        rq_req[2] = 1'b1; rq_addr[2] = 16'h0c02;
        tick(1'b1, 1'b1);
        total++; if ({grant_id, dp_addr} !== {2'd0, 16'h0a00}) begin bad++; $display("FAIL cont_first: got id=%0d addr=%h want 0 0a00", grant_id, dp_addr); end
        respond(16'h0001);
        idle_seen = 0;
        for (int n = 0; n < 4 && dp_req === 1'b1; n++) begin
            tick(1'b1, 1'b1);
            if (grant_id === 2'd3) idle_seen++;
        end
        total++; if ({dp_req, grant_id, dp_addr} !== {1'b0, 2'd2, 16'h0c02}) begin bad++; $display("FAIL cont_second: got req=%b id=%0d addr=%h want 0 2 0c02", dp_req, grant_id, dp_addr); end
        total++; if (idle_seen != 1) begin bad++; $display("FAIL cont_release_gap: got %0d idle samples want 1", idle_seen); end
        respond(16'h0002);
        wait_idle("cont", 1'b0);
        total++; if (rq_ready !== 3'b111) begin bad++; $display("FAIL cont_all_ready: got %b want 111", rq_ready); end
    endtask

    task automatic test_round_robin();
        int exp_id;
        do_reset();
        rq_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
`ifdef DP_ARB_ROUND_ROBIN_EN
            exp_id = k % 3;
`else
            exp_id = 0;
`endif
            wait_grant("rr", 1'b0);
            total++; if (grant_id !== 2'(exp_id)) begin bad++; $display("FAIL rr_order_%0d: got %0d want %0d", k, grant_id, exp_id); end
            respond(16'($urandom));
            wait_idle("rr", 1'b0);
            rq_req[exp_id] = ~rq_req[exp_id];
        end
    endtask

    task automatic test_write();
        do_reset();
        rq_req[0] = 1'b1;
        wait_grant("wr_pre", 1'b0);
        respond(16'h1111);
        wait_idle("wr_pre", 1'b0);
        total++; if (rq_din !== 16'h1111) begin bad++; $display("FAIL wr_preload: got %h want 1111", rq_din); end
        rq_req[2] = 1'b1; rq_write[2] = 1'b1; rq_dout[2] = 16'h5a5a;
        wait_grant("wr", 1'b0);
        total++; if ({grant_id, dp_dout, dp_write} !== {2'd2, 16'h5a5a, 1'b1}) begin bad++; $display("FAIL wr_grant: got id=%0d dout=%h wr=%b want 2 5a5a 1", grant_id, dp_dout, dp_write); end
        respond(16'hdead);
        wait_idle("wr", 1'b0);
        total++; if ({rq_din, rq_ready[2]} !== {16'h1111, 1'b1}) begin bad++; $display("FAIL wr_done: got din=%h ready=%b want 1111 1", rq_din, rq_ready[2]); end
    endtask

    task automatic test_violation();
        do_reset();
        rq_req[0] = 1'b1;
        wait_grant("viol", 1'b0);
        total++; if (implementation_fault !== 1'b0) begin bad++; $display("FAIL viol_before: got %b want 0", implementation_fault); end
        rq_req[0] = 1'b0;
        tick(1'b1, 1'b1);
        respond(16'h4321);
        wait_idle("viol", 1'b0);
        total++; if ({implementation_fault, rq_din} !== {1'b1, 16'h4321}) begin bad++; $display("FAIL viol_after: got fault=%b din=%h want 1 4321", implementation_fault, rq_din); end
        total++; if (rq_ready[0] !== 1'b0) begin bad++; $display("FAIL viol_repending: got ready=%b want 0", rq_ready[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rq_req[0] = 1'b1; rq_addr[0] = 16'habcd;
        wait_grant("rmid", 1'b0);
        respond(16'h7777);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        total++; if ({rq_din, dp_addr, dp_req, grant_id} !== {16'hffff, 16'h0, 1'b0, 2'd3}) begin bad++; $display("FAIL rmid_state: got din=%h addr=%h req=%b id=%0d want ffff 0000 0 3", rq_din, dp_addr, dp_req, grant_id); end
        rq_req = 3'b000; bcu_ack = 1'b0;
        #1;
        total++; if ({rq_ready, implementation_fault} !== 4'b1110) begin bad++; $display("FAIL rmid_ready: got ready=%b fault=%b want 111 0", rq_ready, implementation_fault); end
    endtask

    task automatic test_withdraw();
        do_reset();
        rq_req[1] = 1'b1;
        tick(1'b0, 1'b1);
        rq_req[1] = 1'b0;
        tick(1'b0, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        total++; if ({dp_req, grant_id, implementation_fault, rq_ready} !== {1'b0, 2'd3, 1'b0, 3'b111}) begin bad++; $display("FAIL withdraw: got req=%b id=%0d fault=%b ready=%b want 0 3 0 111", dp_req, grant_id, implementation_fault, rq_ready); end
    endtask

    task automatic test_random();
        logic [15:0] e_addr, e_dout, din;
        logic [1:0]  e_sreg;
        logic [2:0]  e_attr;
        int          w;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend_m(i) && $urandom_range(0, 1) == 1) new_req(i);
            end
            if (pick_m() == 3) new_req(int'($urandom_range(0, 2)));
            w = pick_m();
            e_addr = rq_addr[w]; e_dout = rq_dout[w]; e_sreg = rq_sreg[w];
            e_attr = {rq_write[w], rq_wide[w], rq_io[w]};
            wait_grant("rand", 1'b1);
            total++; if (grant_id !== 2'(w)) begin bad++; $display("FAIL rand_winner_%0d: got %0d want %0d", t, grant_id, w); end
            total++; if ({dp_addr, dp_dout, dp_sreg, dp_write, dp_wide, dp_io} !== {e_addr, e_dout, e_sreg, e_attr}) begin bad++; $display("FAIL rand_fields_%0d: got %h %h %0d %b want %h %h %0d %b", t, dp_addr, dp_dout, dp_sreg, {dp_write, dp_wide, dp_io}, e_addr, e_dout, e_sreg, e_attr); end
            last_m = w;
            rq_addr[w] = 16'($urandom);
            rq_dout[w] = 16'($urandom);
            repeat ($urandom_range(0, 3)) tick_rnd();
            din = 16'($urandom);
            if (!e_attr[2]) din_m = din;
            respond(din);
            wait_idle("rand", 1'b1);
            ack_m[w] = rq_req[w];
            total++; if (rq_din !== din_m) begin bad++; $display("FAIL rand_rq_din_%0d: got %h want %h", t, rq_din, din_m); end
            total++; if (rq_ready !== ~(rq_req ^ ack_m)) begin bad++; $display("FAIL rand_ready_%0d: got %b want %b", t, rq_ready, ~(rq_req ^ ack_m)); end
            total++; if ({dp_addr, dp_dout, implementation_fault} !== {e_addr, e_dout, 1'b0}) begin bad++; $display("FAIL rand_hold_%0d: got %h %h fault=%b want %h %h 0", t, dp_addr, dp_dout, implementation_fault, e_addr, e_dout); end
        end
    endtask

    initial begin
        reset = 1'b1; ce_1 = 1'b0; ce_2 = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_round_robin();
        test_write();
        test_violation();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
